// File: rtl/random_delay_timer_if.sv
// Handshake bundle between the random delay timer and its controller.
// The controller drives start/cancel/randomNumber and observes busy/timeout/delayValue.
interface random_delay_timer_if;
   logic       start;
   logic       cancel;
   logic [3:0] randomNumber;
   logic       busy;
   logic       timeout;
   logic [3:0] delayValue;

   modport master (
      output start,
      output cancel,
      output randomNumber,
      input  busy,
      input  timeout,
      input  delayValue
   );

   modport slave (
      input  start,
      input  cancel,
      input  randomNumber,
      output busy,
      output timeout,
      output delayValue
   );
endinterface

// File: rtl/random_delay_timer.sv
// Captures an LFSR value on start, counts (value + UNIT_OFFSET) units, then pulses timeout.
// Optional RANDOM_DELAY_PRESCALE_EN stretches each unit to TICK_DIV clocks.
module random_delay_timer #(
   parameter int TICK_DIV    = 1000,
   parameter int UNIT_OFFSET = 1
) (
   input  logic               clock,
   input  logic               reset,
   random_delay_timer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE_S  = 2'b00,
      COUNT_S = 2'b01,
      FIRE_S  = 2'b10
   } state_t;

   localparam logic [4:0] OFFSET_C = 5'(UNIT_OFFSET);

   state_t     state_r;
   state_t     state_nx_s;
   logic [4:0] count_r;
   logic [4:0] count_nx_s;
   logic [3:0] delay_r;
   logic [3:0] delay_nx_s;
   logic [4:0] load_s;
   logic       start_ok_s;
   logic       tick_s;
   logic       busy_r;
   logic       timeout_r;

   assign load_s     = {1'b0, bus.randomNumber} + OFFSET_C;
   assign start_ok_s = (state_r == IDLE_S) && bus.start && !bus.cancel;

`ifdef RANDOM_DELAY_PRESCALE_EN
   localparam logic [15:0] TICK_LAST_C = 16'(TICK_DIV - 1);

   logic [15:0] prescale_r;
   logic [15:0] prescale_nx_s;

   assign tick_s = (prescale_r == TICK_LAST_C);

   // Prescaler: cleared on accepted start, free-runs and wraps while counting.
   always_comb begin
      prescale_nx_s = prescale_r;
      if (start_ok_s) begin
         prescale_nx_s = 16'd0;
      end else if ((state_r == COUNT_S) && !bus.cancel) begin
         if (tick_s) begin
            prescale_nx_s = 16'd0;
         end else begin
            prescale_nx_s = prescale_r + 16'd1;
         end
      end else begin
         prescale_nx_s = prescale_r;
      end
   end

   // Prescaler register.
   always_ff @(posedge clock) begin
      if (reset) begin
         prescale_r <= 16'd0;
      end else begin
         prescale_r <= prescale_nx_s;
      end
   end
`else
   assign tick_s = 1'b1;
`endif

   // Next-state, unit counter and captured value; cancel outranks the final tick.
   always_comb begin
      state_nx_s = state_r;
      count_nx_s = count_r;
      delay_nx_s = delay_r;
      case (state_r)
         IDLE_S: begin
            if (start_ok_s) begin
               delay_nx_s = bus.randomNumber;
               count_nx_s = load_s;
               if (load_s == 5'd0) begin
                  state_nx_s = FIRE_S;
               end else begin
                  state_nx_s = COUNT_S;
               end
            end else begin
               state_nx_s = IDLE_S;
            end
         end
         COUNT_S: begin
            if (bus.cancel) begin
               state_nx_s = IDLE_S;
            end else if (tick_s) begin
               count_nx_s = count_r - 5'd1;
               if (count_r == 5'd1) begin
                  state_nx_s = FIRE_S;
               end else begin
                  state_nx_s = COUNT_S;
               end
            end else begin
               state_nx_s = COUNT_S;
            end
         end
         FIRE_S: begin
            state_nx_s = IDLE_S;
         end
         default: begin
            state_nx_s = IDLE_S;
         end
      endcase
   end

   // State, datapath and registered output decodes.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= IDLE_S;
         count_r   <= 5'd0;
         delay_r   <= 4'd0;
         busy_r    <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         count_r   <= count_nx_s;
         delay_r   <= delay_nx_s;
         busy_r    <= (state_nx_s != IDLE_S);
         timeout_r <= (state_nx_s == FIRE_S);
      end
   end

   assign bus.busy       = busy_r;
   assign bus.timeout    = timeout_r;
   assign bus.delayValue = delay_r;

endmodule

// File: tb/tb_random_delay_timer.sv
// Directed self-checking bench: dut1 uses UNIT_OFFSET=1, dut0 uses UNIT_OFFSET=0.
// Expected edge positions scale by TICK_DIV=4 when RANDOM_DELAY_PRESCALE_EN is defined.
module tb_random_delay_timer;

`ifdef RANDOM_DELAY_PRESCALE_EN
   localparam int TF = 4;
`else
   localparam int TF = 1;
`endif

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   random_delay_timer_if bus1 ();
   random_delay_timer_if bus0 ();

   random_delay_timer #(.TICK_DIV(4), .UNIT_OFFSET(1)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1)
   );

   random_delay_timer #(.TICK_DIV(4), .UNIT_OFFSET(0)) dut0 (
      .clock (clock),
      .reset (reset),
      .bus   (bus0)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      checks++;
      if (bus1.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy1 got %b want 0", bus1.busy);
      end
      checks++;
      if (bus1.timeout !== 1'b0) begin
         errors++; $display("FAIL reset_timeout1 got %b want 0", bus1.timeout);
      end
      checks++;
      if (bus1.delayValue !== 4'h0) begin
         errors++; $display("FAIL reset_delay1 got %h want 0", bus1.delayValue);
      end
      checks++;
      if ({bus0.busy, bus0.timeout, bus0.delayValue} !== 6'd0) begin
         errors++; $display("FAIL reset_dut0 got %b want 000000",
                            {bus0.busy, bus0.timeout, bus0.delayValue});
      end
      for (int k = 0; k < 20; k++) begin
         step();
         checks++;
         if ({bus1.busy, bus1.timeout} !== 2'b00) begin
            errors++; $display("FAIL idle_quiet cycle %0d got %b want 00", k,
                               {bus1.busy, bus1.timeout});
         end
      end
   endtask

   task automatic test_basic();
      bus1.randomNumber = 4'h5;
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      bus1.randomNumber = 4'hA;
      checks++;
      if (bus1.delayValue !== 4'h5) begin
         errors++; $display("FAIL basic_delay got %h want 5", bus1.delayValue);
      end
      checks++;
      if ({bus1.busy, bus1.timeout} !== 2'b10) begin
         errors++; $display("FAIL basic_E got %b want 10", {bus1.busy, bus1.timeout});
      end
      for (int k = 1; k <= 6 * TF + 1; k++) begin
         step();
         checks++;
         if ({bus1.busy, bus1.timeout} !== {(k <= 6 * TF), (k == 6 * TF)}) begin
            errors++; $display("FAIL basic_run E+%0d got %b want %b", k,
                               {bus1.busy, bus1.timeout}, {(k <= 6 * TF), (k == 6 * TF)});
         end
      end
   endtask

   task automatic test_max_value();
      bus1.randomNumber = 4'hF;
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      checks++;
      if (bus1.delayValue !== 4'hF) begin
         errors++; $display("FAIL max_delay got %h want f", bus1.delayValue);
      end
      for (int k = 1; k <= 16 * TF + 1; k++) begin
         step();
         checks++;
         if ({bus1.busy, bus1.timeout} !== {(k <= 16 * TF), (k == 16 * TF)}) begin
            errors++; $display("FAIL max_run E+%0d got %b want %b", k,
                               {bus1.busy, bus1.timeout}, {(k <= 16 * TF), (k == 16 * TF)});
         end
      end
   endtask

   task automatic test_zero_load();
      bus0.randomNumber = 4'h0;
      bus0.start = 1'b1;
      step();
      bus0.start = 1'b0;
      checks++;
      if ({bus0.busy, bus0.timeout} !== 2'b11) begin
         errors++; $display("FAIL zero_fire got %b want 11", {bus0.busy, bus0.timeout});
      end
      for (int k = 1; k <= 3; k++) begin
         step();
         checks++;
         if ({bus0.busy, bus0.timeout} !== 2'b00) begin
            errors++; $display("FAIL zero_after E+%0d got %b want 00", k,
                               {bus0.busy, bus0.timeout});
         end
      end
   endtask

   task automatic test_cancel();
      bus1.randomNumber = 4'h9;
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      for (int k = 1; k < 10 * TF; k++) begin
         step();
         checks++;
         if ({bus1.busy, bus1.timeout} !== 2'b10) begin
            errors++; $display("FAIL cancel_run E+%0d got %b want 10", k,
                               {bus1.busy, bus1.timeout});
         end
      end
      bus1.cancel = 1'b1;
      step();
      bus1.cancel = 1'b0;
      checks++;
      if ({bus1.busy, bus1.timeout} !== 2'b00) begin
         errors++; $display("FAIL cancel_final got %b want 00", {bus1.busy, bus1.timeout});
      end
      checks++;
      if (bus1.delayValue !== 4'h9) begin
         errors++; $display("FAIL cancel_keep got %h want 9", bus1.delayValue);
      end
      bus1.randomNumber = 4'h2;
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      checks++;
      if ({bus1.busy, bus1.delayValue} !== 5'b1_0010) begin
         errors++; $display("FAIL restart got %b want 10010", {bus1.busy, bus1.delayValue});
      end
      for (int k = 1; k <= 3 * TF + 1; k++) begin
         step();
         checks++;
         if ({bus1.busy, bus1.timeout} !== {(k <= 3 * TF), (k == 3 * TF)}) begin
            errors++; $display("FAIL restart_run E+%0d got %b want %b", k,
                               {bus1.busy, bus1.timeout}, {(k <= 3 * TF), (k == 3 * TF)});
         end
      end
   endtask

   task automatic test_ignored_start();
      bus1.randomNumber = 4'h3;
      bus1.start = 1'b1;
      step();
      for (int k = 1; k <= 4 * TF + 1; k++) begin
         bus1.randomNumber = 4'(k + 7);
         step();
         checks++;
         if ({bus1.busy, bus1.timeout, bus1.delayValue} !==
             {(k <= 4 * TF), (k == 4 * TF), 4'h3}) begin
            errors++; $display("FAIL ignored_start E+%0d got %b want %b", k,
                               {bus1.busy, bus1.timeout, bus1.delayValue},
                               {(k <= 4 * TF), (k == 4 * TF), 4'h3});
         end
      end
      bus1.start = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      bus1.randomNumber = 4'h7;
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      step();
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({bus1.busy, bus1.timeout, bus1.delayValue} !== 6'd0) begin
         errors++; $display("FAIL reset_mid got %b want 000000",
                            {bus1.busy, bus1.timeout, bus1.delayValue});
      end
      for (int k = 0; k < 10 * TF; k++) begin
         step();
         checks++;
         if ({bus1.busy, bus1.timeout} !== 2'b00) begin
            errors++; $display("FAIL reset_mid_quiet cycle %0d got %b want 00", k,
                               {bus1.busy, bus1.timeout});
         end
      end
   endtask

`ifdef RANDOM_DELAY_PRESCALE_EN
   task automatic test_prescale();
      bus1.randomNumber = 4'h2;
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         step();
         checks++;
         if ({bus1.busy, bus1.timeout} !== {(k <= 12), (k == 12)}) begin
            errors++; $display("FAIL prescale E+%0d got %b want %b", k,
                               {bus1.busy, bus1.timeout}, {(k <= 12), (k == 12)});
         end
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus1.start = 1'b0;
      bus1.cancel = 1'b0;
      bus1.randomNumber = 4'h0;
      bus0.start = 1'b0;
      bus0.cancel = 1'b0;
      bus0.randomNumber = 4'h0;
      test_reset();
      test_basic();
      test_max_value();
      test_zero_load();
      test_cancel();
      test_ignored_start();
      test_reset_mid();
`ifdef RANDOM_DELAY_PRESCALE_EN
      test_prescale();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/random_delay_timer.md
# random_delay_timer

Downstream consumer of the 4-bit LFSR random source. On a start request it captures the current 4-bit random value, converts it into a delay of (value + UNIT_OFFSET) time units, counts that delay down, and fires a one-cycle timeout pulse. It sits between the LFSR and the game/reaction-timer control FSM, which uses the timeout to light the "go" indicator.

## Interface

- TICK_DIV, default 1000: clock cycles per delay unit when the prescaler is compiled in; legal range 2..65535.
- UNIT_OFFSET, default 1: constant added to the captured random value; legal range 0..16.
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- randomNumber  input  4  current LFSR output, sampled only when a start is accepted.
- start  input  1  level-sampled request; accepted only in IDLE.
- cancel  input  1  aborts a running delay without a timeout.
- busy  output  1  high in COUNT and FIRE.
- timeout  output  1  registered one-cycle pulse at the end of the delay.
- delayValue  output  4  random value captured at the last accepted start.

## Operation

- Reset values: state IDLE; busy=0, timeout=0, delayValue=0; unit counter=0, prescaler=0.
- Unit counter is 5 bits wide. Load value = {1'b0, randomNumber} + UNIT_OFFSET; the maximum is 31, so the sum never wraps.
- IDLE:
  - start=1 and cancel=0: delayValue <= randomNumber; counter <= load value; prescaler <= 0.
  - Next state is FIRE if the load value is 0, otherwise COUNT.
  - start=1 and cancel=1 together: start is ignored and the block stays in IDLE.
- COUNT:
  - A tick occurs every cycle (prescaler compiled out), or on the cycle where prescaler == TICK_DIV-1. On that cycle the prescaler wraps to 0; otherwise it increments.
  - On a tick the counter decrements. A tick with counter == 1 moves the state to FIRE.
  - cancel=1 returns the state to IDLE with no timeout; cancel wins over a coincident final tick.
  - start is ignored.
- FIRE: timeout=1 for exactly this cycle; the next state is IDLE unconditionally. start and cancel are ignored.
- busy = (state != IDLE). timeout = (state == FIRE). Both are registered state decodes.
- delayValue holds its value until the next accepted start. Cancel does not clear it.
- Reset asserted in any state forces all reset values on the next edge. A pending timeout is discarded.
- randomNumber is never sampled outside an accepted start, so LFSR stepping during COUNT has no effect.

## Timing

- Let edge E be the edge that accepts start, and N = load value.
- Prescaler out: busy is high from E; timeout is high in the cycle after edge E+N (FIRE entered at E+N); busy is low after edge E+N+1. For N=0, FIRE is entered at E.
- Prescaler in: FIRE is entered at edge E+N*TICK_DIV.
- Minimum spacing between accepted starts: N+2 cycles (prescaler out).
- Throughput: one delay in flight; no queuing of starts.

## Configuration

- RANDOM_DELAY_PRESCALE_EN:
  - Defined: the prescaler counter (16 bits) is instantiated and one unit equals TICK_DIV clocks.
  - Undefined: the prescaler is removed, one unit equals one clock, and TICK_DIV is unused.
  - Ports and FSM are identical in both builds.

## Test plan

- Reset then idle: reset=1 for 2 cycles, then release -> busy=0, timeout=0, delayValue=0; no activity for 20 cycles with start=0.
- Basic delay, prescaler out, UNIT_OFFSET=1: randomNumber=4'h5 with start pulsed at edge E -> delayValue=5, busy=1 from E, FIRE entered at E+6, timeout high for exactly 1 cycle, busy=0 after E+7.
- Boundary values, UNIT_OFFSET=1:
  - randomNumber=4'hF -> timeout after 16 units.
  - With UNIT_OFFSET=0 and randomNumber=4'h0 -> FIRE at E, single timeout pulse.
- Cancel: start with randomNumber=4'h9, assert cancel on the cycle of the final tick -> no timeout, busy=0 next cycle, delayValue stays 9; restart is accepted immediately.
- Ignored start and reset mid-run: start held high during COUNT with randomNumber changing -> delayValue is unchanged and the delay length is unchanged; reset asserted mid-COUNT -> IDLE and all outputs 0 on the next edge, with no timeout.
- Prescaler build, RANDOM_DELAY_PRESCALE_EN defined, TICK_DIV=4, UNIT_OFFSET=1: randomNumber=4'h2 -> FIRE at E+12, timeout width 1 cycle.
